// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register front-end: frame size default,
// downstream register addresses and the receiver FSM encoding.
package spi_regs_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;

  localparam logic [7:0] ADDR_LED = 8'd7;
  localparam logic [7:0] ADDR_MUX = 8'd8;
  localparam logic [7:0] ADDR_DAC = 8'd9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    IDLE_WAIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_frame_rx_pin_sync.sv
// pin_sync: SYNC_STAGES-deep synchroniser plus one history flop; an edge is
// reported whenever the synchronised level differs from the history flop.
module pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_hist;

  // Synchroniser chain and history flop, reset to the pin's idle level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_hist  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
      r_hist  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_level = r_chain[SYNC_STAGES-1];
  assign o_edge  = r_chain[SYNC_STAGES-1] ^ r_hist;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronises the SPI pins, shifts MOSI on SCLK falls and
// strobes valid/err at CS release. Optional inactivity abort: SPI_FRAME_TIMEOUT_EN.
module spi_frame_rx
  import spi_regs_pkg::*;
#(
  parameter int FRAME_BITS     = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_cs,
  input  logic                  i_spi_mosi,
  input  logic                  i_spi_special,
  output logic [FRAME_BITS-9:0] o_frame_addr,
  output logic [7:0]            o_frame_data,
  output logic                  o_frame_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic w_cs_lvl, w_cs_edge, w_sclk_lvl, w_sclk_edge, w_mosi, w_special;
  logic w_cs_rise, w_cs_fall, w_sclk_fall, w_settled;
  logic w_start, w_shift, w_done, w_timeout;
  spi_state_e r_state, w_next;

  logic [FRAME_BITS-1:0] r_sr, r_pend_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic [SET_W-1:0]      r_settle;
  logic r_foreign, r_armed, r_pend_valid, r_pend_err;
  logic r_frame_valid, r_frame_err, r_busy;
  logic [FRAME_BITS-9:0] r_frame_addr;
  logic [7:0]            r_frame_data;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_spi_cs), .o_level(w_cs_lvl), .o_edge(w_cs_edge));
  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_spi_clk), .o_level(w_sclk_lvl), .o_edge(w_sclk_edge));
  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_spi_mosi), .o_level(w_mosi), .o_edge());
  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_special (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_spi_special), .o_level(w_special), .o_edge());

  assign w_cs_rise   = w_cs_edge & w_cs_lvl;
  assign w_cs_fall   = w_cs_edge & ~w_cs_lvl;
  assign w_sclk_fall = w_sclk_edge & ~w_sclk_lvl;
  assign w_settled   = (r_settle == SET_W'(SYNC_STAGES));

  // Arm only once CS has been seen high through a refilled synchroniser, so a CS
  // held low across reset never looks like a fresh falling edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (!w_settled) r_settle <= r_settle + SET_W'(1);
      if (w_settled && w_cs_lvl) r_armed <= 1'b1;
    end
  end

`ifdef SPI_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_hit;
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // SCLK inactivity counter while a frame is open
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start || w_sclk_edge || (r_state != ACTIVE)) begin
      r_to_cnt <= '0;
    end else if (!w_to_hit) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; a CS rise beats a coincident SCLK fall, a CS fall in ACTIVE restarts
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall && r_armed) begin
          w_next  = ACTIVE;
          w_start = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (w_cs_fall) begin
          w_start = 1'b1;
`ifdef SPI_FRAME_TIMEOUT_EN
        end else if (w_to_hit) begin
          w_next    = IDLE_WAIT;
          w_timeout = 1'b1;
`endif
        end else if (w_sclk_fall) begin
          w_shift = 1'b1;
        end else begin
          w_next = ACTIVE;
        end
      end
`ifdef SPI_FRAME_TIMEOUT_EN
      IDLE_WAIT: begin
        if (w_cs_rise) w_next = IDLE;
        else           w_next = IDLE_WAIT;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Shift register, saturating bit counter and foreign flag
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_foreign <= 1'b0;
    end else if (w_shift) begin
      r_sr <= {r_sr[FRAME_BITS-2:0], w_mosi};
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      if (w_special) r_foreign <= 1'b1;
    end
  end

  // Frame verdict, then registered strobes; addr/data only move on a valid frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_err    <= 1'b0;
      r_pend_sr     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_addr  <= '0;
      r_frame_data  <= 8'h00;
      r_busy        <= 1'b0;
    end else begin
      r_pend_valid  <= w_done & ~r_foreign & (r_cnt == CNT_FULL);
      r_pend_err    <= (w_done & ~r_foreign & (r_cnt != CNT_FULL)) | w_timeout;
      if (w_done) r_pend_sr <= r_sr;
      r_frame_valid <= r_pend_valid;
      r_frame_err   <= r_pend_err;
      if (r_pend_valid) begin
        r_frame_addr <= r_pend_sr[FRAME_BITS-1:8];
        r_frame_data <= r_pend_sr[7:0];
      end
      r_busy <= ~w_cs_lvl;
    end
  end

  assign o_frame_addr  = r_frame_addr;
  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised self-checking bench for spi_frame_rx against a frame-level model.
module tb_spi_frame_rx;

  localparam int FB   = 16;
  localparam int SYNC = 2;
`ifdef SPI_FRAME_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  logic clk = 1'b0;
  logic rst, spi_clk, spi_cs, spi_mosi, spi_special;
  logic [7:0] frame_addr, frame_data;
  logic frame_valid, frame_err, busy;

  int vectors = 0, miscompares = 0;
  int cyc = 0, n_valid = 0, n_err = 0, n_both = 0, last_valid_cyc = 0, t_cs_rise = 0;
  logic [15:0] q_valid[$];
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;

  spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(spi_clk), .i_spi_cs(spi_cs),
    .i_spi_mosi(spi_mosi), .i_spi_special(spi_special),
    .o_frame_addr(frame_addr), .o_frame_data(frame_data),
    .o_frame_valid(frame_valid), .o_frame_err(frame_err), .o_busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      n_valid <= n_valid + 1;
      q_valid.push_back({frame_addr, frame_data});
      last_valid_cyc <= cyc;
    end
    if (frame_err) n_err <= n_err + 1;
    if (frame_valid && frame_err) n_both <= n_both + 1;
  end

  // Reference: a non-foreign frame is valid iff exactly FB bits were clocked.
  function automatic void ref_frame(input logic [31:0] bits, input int n, input bit foreign,
                                    output int exp_v, output int exp_e);
    exp_v = 0;
    exp_e = 0;
    if (!foreign) begin
      if (n == FB) begin
        exp_v  = 1;
        m_addr = bits[15:8];
        m_data = bits[7:0];
      end else begin
        exp_e = 1;
      end
    end
  endfunction

  task automatic cs_low(input int hp);
    spi_cs = 1'b0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic sp, input int hp);
    spi_mosi = b;
    spi_special = sp;
    repeat (hp) @(negedge clk);
    spi_clk = 1'b0;
    repeat (hp) @(negedge clk);
    spi_clk = 1'b1;
  endtask

  task automatic cs_high(input int hp);
    repeat (hp) @(negedge clk);
    spi_cs = 1'b1;
    spi_special = 1'b0;
    t_cs_rise = cyc;
  endtask

  task automatic drive_frame(input logic [31:0] bits, input int n, input logic [31:0] smask, input int hp);
    cs_low(hp);
    for (int k = 0; k < n; k++) send_bit(bits[n-1-k], smask[k], hp);
    cs_high(hp);
  endtask

  task automatic test_reset;
    rst = 1'b1; spi_clk = 1'b1; spi_cs = 1'b1; spi_mosi = 1'b0; spi_special = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({frame_addr, frame_data, frame_valid, frame_err, busy} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", {frame_addr, frame_data, frame_valid, frame_err, busy});
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_valid;
    int v0, e0, ev, ee;
    v0 = n_valid; e0 = n_err;
    cs_low(8);
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_low: got %b required 1", busy); end
    for (int k = 0; k < 16; k++) send_bit(16'h0801 >> (15 - k), 1'b0, 8);
    cs_high(8);
    repeat (SYNC + 8) @(negedge clk);
    ref_frame(32'h0801, 16, 1'b0, ev, ee);
    vectors++;
    if (n_valid - v0 !== ev) begin miscompares++; $display("FAIL valid_count: got %0d required %0d", n_valid - v0, ev); end
    vectors++;
    if (n_err - e0 !== ee) begin miscompares++; $display("FAIL valid_err_count: got %0d required %0d", n_err - e0, ee); end
    vectors++;
    if ({frame_addr, frame_data} !== 16'h0801) begin miscompares++; $display("FAIL valid_addr_data: got %h required 0801", {frame_addr, frame_data}); end
    vectors++;
    if (last_valid_cyc !== t_cs_rise + SYNC + 2) begin
      miscompares++; $display("FAIL latency: got %0d required %0d", last_valid_cyc - t_cs_rise, SYNC + 2);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_high: got %b required 0", busy); end
  endtask

  task automatic test_bad_length;
    int v0, e0, ev, ee;
    int lens[2] = '{15, 17};
    foreach (lens[i]) begin
      v0 = n_valid; e0 = n_err;
      drive_frame(32'h1ABCD, lens[i], 32'd0, 5);
      repeat (SYNC + 8) @(negedge clk);
      ref_frame(32'h1ABCD, lens[i], 1'b0, ev, ee);
      vectors++;
      if (n_err - e0 !== ee) begin miscompares++; $display("FAIL bad_len_err n=%0d: got %0d required %0d", lens[i], n_err - e0, ee); end
      vectors++;
      if (n_valid - v0 !== ev) begin miscompares++; $display("FAIL bad_len_valid n=%0d: got %0d required %0d", lens[i], n_valid - v0, ev); end
      vectors++;
      if ({frame_addr, frame_data} !== {m_addr, m_data}) begin
        miscompares++; $display("FAIL bad_len_hold n=%0d: got %h required %h", lens[i], {frame_addr, frame_data}, {m_addr, m_data});
      end
    end
  endtask

  task automatic test_foreign;
    int v0, e0, ev, ee;
    v0 = n_valid; e0 = n_err;
    drive_frame(32'h0703, 16, 32'h70, 6);
    repeat (SYNC + 8) @(negedge clk);
    ref_frame(32'h0703, 16, 1'b1, ev, ee);
    vectors++;
    if ((n_valid - v0) + (n_err - e0) !== ev + ee) begin
      miscompares++; $display("FAIL foreign_strobe: got %0d required %0d", (n_valid - v0) + (n_err - e0), ev + ee);
    end
    vectors++;
    if ({frame_addr, frame_data} !== {m_addr, m_data}) begin
      miscompares++; $display("FAIL foreign_hold: got %h required %h", {frame_addr, frame_data}, {m_addr, m_data});
    end
  endtask

  task automatic test_reset_midframe;
    int v0, e0, ev, ee;
    v0 = n_valid; e0 = n_err;
    cs_low(5);
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_addr = 8'h00; m_data = 8'h00;
    cs_high(5);
    repeat (SYNC + 8) @(negedge clk);
    vectors++;
    if ((n_valid - v0) + (n_err - e0) !== 0) begin
      miscompares++; $display("FAIL midreset_strobe: got %0d required 0", (n_valid - v0) + (n_err - e0));
    end
    vectors++;
    if ({frame_addr, frame_data} !== {m_addr, m_data}) begin
      miscompares++; $display("FAIL midreset_clear: got %h required %h", {frame_addr, frame_data}, {m_addr, m_data});
    end
    v0 = n_valid;
    drive_frame(32'h090F, 16, 32'd0, 4);
    repeat (SYNC + 8) @(negedge clk);
    ref_frame(32'h090F, 16, 1'b0, ev, ee);
    vectors++;
    if (n_valid - v0 !== ev) begin miscompares++; $display("FAIL midreset_next_count: got %0d required %0d", n_valid - v0, ev); end
    vectors++;
    if ({frame_addr, frame_data} !== {m_addr, m_data}) begin
      miscompares++; $display("FAIL midreset_next_data: got %h required %h", {frame_addr, frame_data}, {m_addr, m_data});
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    drive_frame(32'h07AA, 16, 32'd0, 4);
    repeat (4) @(negedge clk);
    drive_frame(32'h0755, 16, 32'd0, 4);
    repeat (SYNC + 8) @(negedge clk);
    m_addr = 8'h07; m_data = 8'h55;
    vectors++;
    if (n_valid - v0 !== 2) begin
      miscompares++; $display("FAIL b2b_count: got %0d required 2", n_valid - v0);
    end else begin
      vectors++;
      if (q_valid[q_valid.size()-2] !== 16'h07AA || q_valid[q_valid.size()-1] !== 16'h0755) begin
        miscompares++; $display("FAIL b2b_data: got %h,%h required 07aa,0755", q_valid[q_valid.size()-2], q_valid[q_valid.size()-1]);
      end
    end
  endtask

  task automatic test_random;
    int v0, e0, ev, ee, n, hp, sel;
    logic [31:0] bits, smask;
    bit foreign;
    for (int it = 0; it < 24; it++) begin
      sel  = $urandom_range(0, 5);
      n    = (sel == 0) ? 15 : (sel == 1) ? 17 : (sel == 2) ? int'($urandom_range(1, 20)) : 16;
      bits = $urandom;
      hp   = $urandom_range(3, 8);
      foreign = ($urandom_range(0, 3) == 0);
      smask = foreign ? (32'd1 << $urandom_range(0, n - 1)) : 32'd0;
      v0 = n_valid; e0 = n_err;
      drive_frame(bits, n, smask, hp);
      repeat (SYNC + 8) @(negedge clk);
      ref_frame(bits, n, foreign, ev, ee);
      vectors++;
      if (n_valid - v0 !== ev) begin miscompares++; $display("FAIL rand_valid it=%0d n=%0d: got %0d required %0d", it, n, n_valid - v0, ev); end
      vectors++;
      if (n_err - e0 !== ee) begin miscompares++; $display("FAIL rand_err it=%0d n=%0d: got %0d required %0d", it, n, n_err - e0, ee); end
      vectors++;
      if ({frame_addr, frame_data} !== {m_addr, m_data}) begin
        miscompares++; $display("FAIL rand_data it=%0d: got %h required %h", it, {frame_addr, frame_data}, {m_addr, m_data});
      end
    end
  endtask

`ifdef SPI_FRAME_TIMEOUT_EN
  task automatic test_timeout;
    int v0, e0, ev, ee;
    v0 = n_valid; e0 = n_err;
    cs_low(4);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0, 4);
    repeat (TO + 20) @(negedge clk);
    vectors++;
    if (n_err - e0 !== 1) begin miscompares++; $display("FAIL timeout_err: got %0d required 1", n_err - e0); end
    cs_high(1);
    repeat (SYNC + 8) @(negedge clk);
    vectors++;
    if ((n_err - e0) + (n_valid - v0) !== 1) begin
      miscompares++; $display("FAIL timeout_release: got %0d strobes required 1", (n_err - e0) + (n_valid - v0));
    end
    v0 = n_valid;
    drive_frame(32'h08C3, 16, 32'd0, 4);
    repeat (SYNC + 8) @(negedge clk);
    ref_frame(32'h08C3, 16, 1'b0, ev, ee);
    vectors++;
    if (n_valid - v0 !== ev || {frame_addr, frame_data} !== {m_addr, m_data}) begin
      miscompares++; $display("FAIL timeout_next: got %0d/%h required %0d/%h", n_valid - v0, {frame_addr, frame_data}, ev, {m_addr, m_data});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_valid();
    test_bad_length();
    test_foreign();
    test_reset_midframe();
    test_back_to_back();
    test_random();
`ifdef SPI_FRAME_TIMEOUT_EN
    test_timeout();
`endif
    vectors++;
    if (n_both !== 0) begin miscompares++; $display("FAIL both_strobes: got %0d required 0", n_both); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
